hilo_mdu_ctrl: RTL and testbench

- Multi-cycle multiply/divide controller for the EX stage of the MIPS pipeline. It owns the architectural HI/LO registers.
- Multiplies are split into MUL_LAT register stages. Divides run an iterative 32-step restoring divider.
- It stalls the pipeline while an operation is in flight. Pending work is cancelled on an exception flush.

---
 rtl/hilo_mdu_pkg.sv | 23 ++
 rtl/mdu_div_core.sv | 59 +++++
 rtl/hilo_mdu_ctrl.sv | 151 +++++++++++++++
 tb/tb_hilo_mdu_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_mdu_pkg.sv
// rtl/hilo_mdu_pkg.sv - shared op codes, FSM states and divider constants for the HI/LO MDU
package hilo_mdu_pkg;

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MTHI  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;
  localparam logic [3:0] OP_MADD  = 4'd6;
  localparam logic [3:0] OP_MADDU = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8;
  localparam logic [3:0] OP_MSUBU = 4'd9;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIN} mdu_state_t;

  localparam int DIV_STEPS = 32;

  function automatic logic is_signed_op(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// rtl/mdu_div_core.sv - unsigned 32-step restoring divider on operand magnitudes
module mdu_div_core
  import hilo_mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        kill,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        step_last
);

  logic        busy;
  logic [4:0]  cnt;
  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] dvs_q;
  logic [32:0] shifted;
  logic [32:0] diff;
  logic        ge;

  // Partial remainder stays below the divisor, so diff[32] is a clean borrow flag.
  always_comb begin
    shifted   = {rem_q, quo_q[31]};
    diff      = shifted - {1'b0, dvs_q};
    ge        = ~diff[32];
    quotient  = {quo_q[30:0], ge};
    remainder = ge ? diff[31:0] : shifted[31:0];
    step_last = busy && (cnt == 5'(DIV_STEPS - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy  <= 1'b0;
      cnt   <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (kill) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      cnt   <= '0;
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
    end else if (busy) begin
      rem_q <= remainder;
      quo_q <= quotient;
      cnt   <= cnt + 5'd1;
      if (step_last) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/hilo_mdu_ctrl.sv
// rtl/hilo_mdu_ctrl.sv - EX-stage MDU controller owning HI/LO; HILO_MDU_MADD_EN enables MADD/MSUB
module hilo_mdu_ctrl
  import hilo_mdu_pkg::*;
#(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [3:0]  op_code,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        flush,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

`ifdef HILO_MDU_MADD_EN
  localparam bit MADD_EN = 1'b1;
`else
  localparam bit MADD_EN = 1'b0;
`endif

  localparam logic [2:0] MUL_LAST = 3'(MUL_LAT - 1);

  mdu_state_t  state;
  logic [2:0]  cnt;
  logic [31:0] a_q, b_q;
  logic [3:0]  op_q;
  logic        neg_q, neg_r;
  logic        done_q;
  logic [31:0] hi_q, lo_q;

  logic        is_mul_op, is_div_op, op_signed, div_start;
  logic [31:0] dividend, divisor, quotient, remainder;
  logic        step_last;
  logic [63:0] ext_a, ext_b, prod, mul_res;

  always_comb begin
    is_mul_op = (op_code == OP_MULT) || (op_code == OP_MULTU) ||
                (MADD_EN && (op_code >= OP_MADD) && (op_code <= OP_MSUBU));
    is_div_op = (op_code == OP_DIV) || (op_code == OP_DIVU);
    op_signed = is_signed_op(op_code);
    div_start = (state == ST_IDLE) && op_valid && !flush && is_div_op && (src2 != 32'd0);
    dividend  = (op_signed && src1[31]) ? (~src1 + 32'd1) : src1;
    divisor   = (op_signed && src2[31]) ? (~src2 + 32'd1) : src2;
  end

  // Flush masks only a new acceptance; an op already in flight keeps stalling until the flush edge.
  assign stall = ((state == ST_IDLE) && op_valid && !flush && (is_mul_op || is_div_op)) ||
                 (state == ST_MUL) || (state == ST_DIV);

  // Low 64 bits of the extended product are correct for both signed and unsigned operands.
  always_comb begin
    ext_a   = is_signed_op(op_q) ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
    ext_b   = is_signed_op(op_q) ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
    prod    = ext_a * ext_b;
    mul_res = prod;
    if (MADD_EN && (op_q == OP_MADD || op_q == OP_MADDU)) mul_res = {hi_q, lo_q} + prod;
    if (MADD_EN && (op_q == OP_MSUB || op_q == OP_MSUBU)) mul_res = {hi_q, lo_q} - prod;
  end

  mdu_div_core u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .kill      (flush),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .step_last (step_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (flush) begin
        state <= ST_IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (op_valid) begin
              if (is_mul_op) begin
                a_q   <= src1;
                b_q   <= src2;
                op_q  <= op_code;
                cnt   <= '0;
                state <= ST_MUL;
              end else if (is_div_op) begin
                if (src2 == 32'd0) begin
                  hi_q   <= '0;
                  lo_q   <= '0;
                  done_q <= 1'b1;
                  state  <= ST_FIN;
                end else begin
                  neg_q <= op_signed && (src1[31] ^ src2[31]);
                  neg_r <= op_signed && src1[31];
                  cnt   <= '0;
                  state <= ST_DIV;
                end
              end else if (op_code == OP_MTHI) begin
                hi_q <= src1;
              end else if (op_code == OP_MTLO) begin
                lo_q <= src1;
              end
            end
          end
          ST_MUL: begin
            if (cnt == MUL_LAST) begin
              {hi_q, lo_q} <= mul_res;
              done_q       <= 1'b1;
              cnt          <= '0;
              state        <= ST_FIN;
            end else begin
              cnt <= cnt + 3'd1;
            end
          end
          ST_DIV: begin
            if (step_last) begin
              lo_q   <= neg_q ? (~quotient + 32'd1) : quotient;
              hi_q   <= neg_r ? (~remainder + 32'd1) : remainder;
              done_q <= 1'b1;
              state  <= ST_FIN;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
// tb/tb_hilo_mdu_ctrl.sv - self-checking bench for hilo_mdu_ctrl with a behavioural HI/LO model
module tb_hilo_mdu_ctrl;

  localparam int MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        rst, op_valid, flush;
  logic [3:0]  op_code;
  logic [31:0] src1, src2;
  logic        stall, done;
  logic [31:0] hi, lo;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always #5 clk = ~clk;

  hilo_mdu_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk      (clk),
    .rst      (rst),
    .op_valid (op_valid),
    .op_code  (op_code),
    .src1     (src1),
    .src2     (src2),
    .flush    (flush),
    .stall    (stall),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit madd_en();
`ifdef HILO_MDU_MADD_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Reference: updates m_hi/m_lo and returns cycles from acceptance to done (0 = single-cycle/no-op).
  task automatic model(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b, output int lat);
    longint      sa, sb;
    logic [63:0] p, acc;
    logic [31:0] q, r;
    lat = 0;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    acc = {m_hi, m_lo};
    case (code)
      4'd0, 4'd6, 4'd8: p = 64'(sa * sb);
      default:          p = {32'd0, a} * {32'd0, b};
    endcase
    case (code)
      4'd0, 4'd1: begin {m_hi, m_lo} = p; lat = 1 + MUL_LAT; end
      4'd6, 4'd7: if (madd_en()) begin {m_hi, m_lo} = acc + p; lat = 1 + MUL_LAT; end
      4'd8, 4'd9: if (madd_en()) begin {m_hi, m_lo} = acc - p; lat = 1 + MUL_LAT; end
      4'd2, 4'd3: begin
        if (b == 32'd0) begin
          m_hi = '0; m_lo = '0; lat = 1;
        end else begin
          if (code == 4'd3) begin
            q = a / b; r = a % b;
          end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a; r = '0;
          end else begin
            q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
          end
          m_lo = q; m_hi = r; lat = 33;
        end
      end
      4'd4: m_hi = a;
      4'd5: m_lo = a;
      default: ;
    endcase
  endtask

  task automatic run_op(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] pre_hi, pre_lo;
    int lat;
    pre_hi = m_hi;
    pre_lo = m_lo;
    @(negedge clk);
    op_valid = 1'b1; op_code = code; src1 = a; src2 = b;
    model(code, a, b, lat);
    #1 chk({tag, " stall_at_accept"}, stall, (lat > 0));
    if (lat == 0) begin
      @(negedge clk);
      op_valid = 1'b0;
      #1;
      chk({tag, " hi"}, hi, m_hi);
      chk({tag, " lo"}, lo, m_lo);
      chk({tag, " done"}, done, 0);
      chk({tag, " stall"}, stall, 0);
    end else begin
      for (int n = 1; n < lat; n++) begin
        @(negedge clk);
        #1;
        chk({tag, " stall_busy"}, stall, 1);
        chk({tag, " done_busy"}, done, 0);
        chk({tag, " hilo_busy"}, {hi, lo}, {pre_hi, pre_lo});
      end
      @(negedge clk);
      #1;
      chk({tag, " done_fin"}, done, 1);
      chk({tag, " stall_fin"}, stall, 0);
      chk({tag, " hi"}, hi, m_hi);
      chk({tag, " lo"}, lo, m_lo);
      op_valid = 1'b0;
      @(negedge clk);
      #1;
      chk({tag, " done_after"}, done, 0);
      chk({tag, " stall_after"}, stall, 0);
    end
  endtask

  initial begin
    logic seen_done;
    rst = 1'b1; op_valid = 1'b0; flush = 1'b0; op_code = '0; src1 = '0; src2 = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset hi", hi, 0);
    chk("reset lo", lo, 0);
    chk("reset stall", stall, 0);
    chk("reset done", done, 0);
    rst = 1'b0;

    run_op(4'd0, 32'hFFFF_FFFE, 32'd3, "mult_neg2x3");
    run_op(4'd2, 32'hFFFF_FFF9, 32'd2, "div_neg7by2");
    run_op(4'd3, 32'hFFFF_FFF9, 32'd2, "divu_same");
    run_op(4'd2, 32'd5, 32'd0, "div_by_zero");
    run_op(4'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
    run_op(4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");

    // MTHI then MTLO in back-to-back IDLE cycles
    @(negedge clk);
    op_valid = 1'b1; op_code = 4'd4; src1 = 32'h1234_5678;
    #1 chk("mthi stall", stall, 0);
    @(negedge clk);
    op_code = 4'd5; src1 = 32'h9ABC_DEF0;
    #1;
    chk("mthi hi", hi, 32'h1234_5678);
    chk("mthi done", done, 0);
    chk("mtlo stall", stall, 0);
    @(negedge clk);
    op_valid = 1'b0;
    #1;
    chk("mtlo lo", lo, 32'h9ABC_DEF0);
    chk("mtlo hi_kept", hi, 32'h1234_5678);
    chk("mtlo done", done, 0);
    m_hi = 32'h1234_5678; m_lo = 32'h9ABC_DEF0;

    // Flush in DIV cycle 10
    @(negedge clk);
    op_valid = 1'b1; op_code = 4'd3; src1 = 32'd1000; src2 = 32'd7;
    #1 chk("flushdiv stall_accept", stall, 1);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    #1 chk("flushdiv stall_in_div", stall, 1);
    @(negedge clk);
    flush = 1'b0; op_valid = 1'b0;
    #1;
    chk("flushdiv stall", stall, 0);
    chk("flushdiv done", done, 0);
    chk("flushdiv hilo", {hi, lo}, {m_hi, m_lo});
    seen_done = 1'b0;
    repeat (30) begin @(negedge clk); #1 seen_done |= done; end
    chk("flushdiv no_late_done", seen_done, 0);
    chk("flushdiv hilo_late", {hi, lo}, {m_hi, m_lo});

    // Flush together with a new op: nothing accepted
    @(negedge clk);
    op_valid = 1'b1; op_code = 4'd0; src1 = 32'd3; src2 = 32'd3; flush = 1'b1;
    #1 chk("flushacc stall", stall, 0);
    @(negedge clk);
    flush = 1'b0; op_valid = 1'b0;
    #1 chk("flushacc stall_next", stall, 0);
    seen_done = 1'b0;
    repeat (5) begin @(negedge clk); #1 seen_done |= done; end
    chk("flushacc no_done", seen_done, 0);
    chk("flushacc hilo", {hi, lo}, {m_hi, m_lo});

    // Reset during MUL
    @(negedge clk);
    op_valid = 1'b1; op_code = 4'd0; src1 = 32'd5; src2 = 32'd6;
    @(negedge clk);
    rst = 1'b1; op_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstmul hilo", {hi, lo}, 64'd0);
    chk("rstmul stall", stall, 0);
    chk("rstmul done", done, 0);
    m_hi = '0; m_lo = '0;
    seen_done = 1'b0;
    repeat (5) begin @(negedge clk); #1 seen_done |= done; end
    chk("rstmul no_done", seen_done, 0);

    // MADDU accumulate (no-op when the feature is absent)
    run_op(4'd4, 32'd0, 32'd0, "pre_mthi");
    run_op(4'd5, 32'hFFFF_FFFF, 32'd0, "pre_mtlo");
    run_op(4'd7, 32'd1, 32'd1, "maddu_1x1");
    run_op(4'd8, 32'hFFFF_FFFD, 32'd4, "msub_neg");
    run_op(4'd13, 32'hDEAD_BEEF, 32'd1, "unknown_op");

    for (int i = 0; i < 30; i++) begin
      logic [3:0]  c;
      logic [31:0] a, b;
      c = 4'($urandom_range(0, 11));
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 :
          ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      if ($urandom_range(0, 3) == 0) a = {1'b1, 31'($urandom_range(0, 1000))};
      run_op(c, a, b, $sformatf("rand%0d_op%0d", i, c));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
